// File: rtl/vc_route_unit.sv
// rtl/vc_route_unit.sv - per-VC dimension-ordered route computation stage
module vc_route_unit #(
    parameter int X_CURRENT    = 0,
    parameter int Y_CURRENT    = 0,
    parameter int X_ADDR_W     = 4,
    parameter int Y_ADDR_W     = 4,
    parameter int VC_NUM       = 4,
    parameter int ROUTING_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [$clog2(VC_NUM)-1:0] in_vc,
    input  logic [1:0]                in_flit_type,
    input  logic [X_ADDR_W-1:0]       in_x_dest,
    input  logic [Y_ADDR_W-1:0]       in_y_dest,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(VC_NUM)-1:0] out_vc,
    output logic [1:0]                out_flit_type,
    output logic [2:0]                out_port,
    output logic [VC_NUM-1:0]         vc_active,
    output logic                      err_protocol
);

    localparam int VC_W = $clog2(VC_NUM);

    // Next-hop port encoding shared with the switch allocator.
    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_NORTH = 3'd1;
    localparam logic [2:0] PORT_SOUTH = 3'd2;
    localparam logic [2:0] PORT_EAST  = 3'd3;
    localparam logic [2:0] PORT_WEST  = 3'd4;

    localparam logic [1:0] FLIT_HEAD     = 2'b00;
    localparam logic [1:0] FLIT_BODY     = 2'b01;
    localparam logic [1:0] FLIT_TAIL     = 2'b10;
    localparam logic [1:0] FLIT_HEADTAIL = 2'b11;

    // Router coordinates widened by one bit so offsets are true signed values.
    localparam logic signed [X_ADDR_W:0] X_CUR_S = (X_ADDR_W+1)'(X_CURRENT);
    localparam logic signed [Y_ADDR_W:0] Y_CUR_S = (Y_ADDR_W+1)'(Y_CURRENT);

    typedef enum logic {
        VC_IDLE   = 1'b0,
        VC_ACTIVE = 1'b1
    } vc_state_t;

    vc_state_t              vc_state_q [VC_NUM];
    vc_state_t              vc_state_d [VC_NUM];
    logic [2:0]             route_q    [VC_NUM];
    logic [2:0]             route_d    [VC_NUM];

    logic                   out_valid_q, out_valid_d;
    logic [VC_W-1:0]        out_vc_q, out_vc_d;
    logic [1:0]             out_type_q, out_type_d;
    logic [2:0]             out_port_q, out_port_d;
    logic                   err_q, err_d;

    logic signed [X_ADDR_W:0] dx;
    logic signed [Y_ADDR_W:0] dy;
    logic                   dx_neg, dx_pos, dy_neg, dy_pos;
    logic [2:0]             new_route;
    logic                   load;
    logic                   sel_active;

    // Signed offsets: the destination is zero-extended before subtracting.
    assign dx = $signed({1'b0, in_x_dest}) - X_CUR_S;
    assign dy = $signed({1'b0, in_y_dest}) - Y_CUR_S;

    // Dimension-ordered route for the incoming head flit.
    always_comb begin
        dx_neg    = dx[X_ADDR_W];
        dx_pos    = !dx[X_ADDR_W] && (dx != '0);
        dy_neg    = dy[Y_ADDR_W];
        dy_pos    = !dy[Y_ADDR_W] && (dy != '0);
        new_route = PORT_LOCAL;
        if (ROUTING_MODE == 0) begin
            if (dx_neg)      new_route = PORT_WEST;
            else if (dx_pos) new_route = PORT_EAST;
            else if (dy_neg) new_route = PORT_NORTH;
            else if (dy_pos) new_route = PORT_SOUTH;
            else             new_route = PORT_LOCAL;
        end else begin
            if (dy_neg)      new_route = PORT_NORTH;
            else if (dy_pos) new_route = PORT_SOUTH;
            else if (dx_neg) new_route = PORT_WEST;
            else if (dx_pos) new_route = PORT_EAST;
            else             new_route = PORT_LOCAL;
        end
    end

    // Ready whenever the output register is empty or being drained; also during reset.
    assign in_ready   = !rst_n || !out_valid_q || out_ready;
    assign load       = in_valid && in_ready;
    assign sel_active = (vc_state_q[in_vc] == VC_ACTIVE);

    // Per-VC state machine and output register next-state.
    always_comb begin
        vc_state_d  = vc_state_q;
        route_d     = route_q;
        out_vc_d    = out_vc_q;
        out_type_d  = out_type_q;
        out_port_d  = out_port_q;
        out_valid_d = out_valid_q && !out_ready;
        err_d       = 1'b0;
        if (load) begin
            out_valid_d = 1'b1;
            out_vc_d    = in_vc;
            out_type_d  = in_flit_type;
            case (in_flit_type)
                FLIT_HEAD: begin
                    out_port_d        = new_route;
                    route_d[in_vc]    = new_route;
                    vc_state_d[in_vc] = VC_ACTIVE;
                    err_d             = sel_active;
                end
                FLIT_HEADTAIL: begin
                    out_port_d        = new_route;
                    vc_state_d[in_vc] = VC_IDLE;
                    err_d             = sel_active;
                end
                FLIT_BODY: begin
                    if (sel_active) begin
                        out_port_d = route_q[in_vc];
                    end else begin
                        out_port_d = PORT_LOCAL;
                        err_d      = 1'b1;
                    end
                end
                FLIT_TAIL: begin
                    if (sel_active) begin
                        out_port_d        = route_q[in_vc];
                        vc_state_d[in_vc] = VC_IDLE;
                    end else begin
                        out_port_d = PORT_LOCAL;
                        err_d      = 1'b1;
                    end
                end
            endcase
        end
    end

    // State, stored routes and output register all update on the load edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < VC_NUM; i++) begin
                vc_state_q[i] <= VC_IDLE;
                route_q[i]    <= PORT_LOCAL;
            end
            out_valid_q <= 1'b0;
            out_vc_q    <= '0;
            out_type_q  <= FLIT_HEAD;
            out_port_q  <= PORT_LOCAL;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < VC_NUM; i++) begin
                vc_state_q[i] <= vc_state_d[i];
                route_q[i]    <= route_d[i];
            end
            out_valid_q <= out_valid_d;
            out_vc_q    <= out_vc_d;
            out_type_q  <= out_type_d;
            out_port_q  <= out_port_d;
            err_q       <= err_d;
        end
    end

    // Expose which VCs currently hold a route.
    always_comb begin
        vc_active = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            vc_active[i] = (vc_state_q[i] == VC_ACTIVE);
        end
    end

    assign out_valid     = out_valid_q;
    assign out_vc        = out_vc_q;
    assign out_flit_type = out_type_q;
    assign out_port      = out_port_q;
    assign err_protocol  = err_q;

endmodule

// File: tb/tb_vc_route_unit.sv
// tb/tb_vc_route_unit.sv - scoreboard bench for vc_route_unit on three router configurations
module tb_vc_route_unit;

    localparam logic [2:0] LOCAL = 3'd0;
    localparam logic [2:0] NORTH = 3'd1;
    localparam logic [2:0] SOUTH = 3'd2;
    localparam logic [2:0] EAST  = 3'd3;
    localparam logic [2:0] WEST  = 3'd4;

    localparam logic [1:0] HEAD     = 2'b00;
    localparam logic [1:0] BODY     = 2'b01;
    localparam logic [1:0] TAIL     = 2'b10;
    localparam logic [1:0] HEADTAIL = 2'b11;

    // Instance k: 0 = (2,2) XY, 1 = (2,2) YX, 2 = (5,5) XY
    int XC [3] = '{2, 2, 5};
    int YC [3] = '{2, 2, 5};
    int MD [3] = '{0, 1, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_vc;
    logic [1:0] in_flit_type;
    logic [3:0] in_x_dest;
    logic [3:0] in_y_dest;
    logic       out_ready;

    logic       rdy   [3];
    logic       ov    [3];
    logic [1:0] ovc   [3];
    logic [1:0] otype [3];
    logic [2:0] oport [3];
    logic [3:0] vca   [3];
    logic       err   [3];

    typedef struct {
        logic [1:0]      vc;
        logic [1:0]      ftype;
        logic [2:0][2:0] port;
        logic            err;
    } exp_t;

    exp_t sbq [$];

    int   checks   = 0;
    int   failures = 0;

    logic [3:0] m_active;
    int         m_route [3][4];

    always #5 clk = ~clk;

    vc_route_unit #(.X_CURRENT(2), .Y_CURRENT(2), .X_ADDR_W(4), .Y_ADDR_W(4), .VC_NUM(4), .ROUTING_MODE(0)) dut_xy (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[0]), .in_vc(in_vc),
        .in_flit_type(in_flit_type), .in_x_dest(in_x_dest), .in_y_dest(in_y_dest),
        .out_valid(ov[0]), .out_ready(out_ready), .out_vc(ovc[0]), .out_flit_type(otype[0]),
        .out_port(oport[0]), .vc_active(vca[0]), .err_protocol(err[0]));

    vc_route_unit #(.X_CURRENT(2), .Y_CURRENT(2), .X_ADDR_W(4), .Y_ADDR_W(4), .VC_NUM(4), .ROUTING_MODE(1)) dut_yx (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[1]), .in_vc(in_vc),
        .in_flit_type(in_flit_type), .in_x_dest(in_x_dest), .in_y_dest(in_y_dest),
        .out_valid(ov[1]), .out_ready(out_ready), .out_vc(ovc[1]), .out_flit_type(otype[1]),
        .out_port(oport[1]), .vc_active(vca[1]), .err_protocol(err[1]));

    vc_route_unit #(.X_CURRENT(5), .Y_CURRENT(5), .X_ADDR_W(4), .Y_ADDR_W(4), .VC_NUM(4), .ROUTING_MODE(0)) dut_55 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy[2]), .in_vc(in_vc),
        .in_flit_type(in_flit_type), .in_x_dest(in_x_dest), .in_y_dest(in_y_dest),
        .out_valid(ov[2]), .out_ready(out_ready), .out_vc(ovc[2]), .out_flit_type(otype[2]),
        .out_port(oport[2]), .vc_active(vca[2]), .err_protocol(err[2]));

    function automatic logic [2:0] ref_route(input int xc, input int yc, input int mode,
                                             input int xd, input int yd);
        int ddx;
        int ddy;
        ddx = xd - xc;
        ddy = yd - yc;
        if (mode == 0) begin
            if (ddx < 0) return WEST;
            if (ddx > 0) return EAST;
            if (ddy < 0) return NORTH;
            if (ddy > 0) return SOUTH;
            return LOCAL;
        end
        if (ddy < 0) return NORTH;
        if (ddy > 0) return SOUTH;
        if (ddx < 0) return WEST;
        if (ddx > 0) return EAST;
        return LOCAL;
    endfunction

    task automatic model_reset();
        m_active = 4'b0000;
        for (int k = 0; k < 3; k++)
            for (int v = 0; v < 4; v++) m_route[k][v] = int'(LOCAL);
    endtask

    task automatic push_exp(input int vc, input logic [1:0] ft, input int xd, input int yd);
        exp_t e;
        e.vc    = 2'(vc);
        e.ftype = ft;
        e.err   = 1'b0;
        e.port  = '0;
        if (ft == HEAD || ft == HEADTAIL) begin
            e.err = m_active[vc];
            for (int k = 0; k < 3; k++) begin
                e.port[k] = ref_route(XC[k], YC[k], MD[k], xd, yd);
                if (ft == HEAD) m_route[k][vc] = int'(e.port[k]);
            end
            m_active[vc] = (ft == HEAD);
        end else if (m_active[vc]) begin
            for (int k = 0; k < 3; k++) e.port[k] = 3'(m_route[k][vc]);
            if (ft == TAIL) m_active[vc] = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) e.port[k] = LOCAL;
            e.err = 1'b1;
        end
        sbq.push_back(e);
    endtask

    // Present a flit (called at a falling edge) and return at the falling edge after it transfers.
    task automatic send(input int vc, input logic [1:0] ft, input int xd, input int yd);
        int n;
        in_vc        = 2'(vc);
        in_flit_type = ft;
        in_x_dest    = 4'(xd);
        in_y_dest    = 4'(yd);
        in_valid     = 1'b1;
        n = 0;
        while (rdy[0] !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; failures++;
            $display("FAIL send_timeout vc=%0d type=%0d in_ready never rose", vc, ft);
        end else begin
            push_exp(vc, ft, xd, yd);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic check_vca(input string name, input logic [3:0] want);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (vca[k] !== want) begin
                failures++;
                $display("FAIL %s dut=%0d vc_active=%b expected=%b", name, k, vca[k], want);
            end
        end
    endtask

    // Output monitor: sampled mid-cycle; pops on each handshake, checks err on each new output.
    logic prev_valid = 1'b0;
    logic prev_hs    = 1'b0;
    always begin
        logic fresh;
        logic hs;
        exp_t e;
        @(negedge clk);
        #1;
        if (rst_n !== 1'b1) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            fresh = ov[0] && (!prev_valid || prev_hs);
            hs    = ov[0] && out_ready;
            if (fresh) begin
                if (sbq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output vc=%0d type=%0d port=%0d", ovc[0], otype[0], oport[0]);
                end else begin
                    for (int k = 0; k < 3; k++) begin
                        checks++;
                        if (err[k] !== sbq[0].err || ov[k] !== 1'b1) begin
                            failures++;
                            $display("FAIL err_pulse dut=%0d err=%b valid=%b expected err=%b", k, err[k], ov[k], sbq[0].err);
                        end
                    end
                end
            end else begin
                checks++;
                if (err[0] !== 1'b0) begin
                    failures++;
                    $display("FAIL err_stray err=%b expected=0", err[0]);
                end
            end
            if (hs && sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (ovc[0] !== e.vc || otype[0] !== e.ftype) begin
                    failures++;
                    $display("FAIL out_tag vc=%0d type=%0d expected vc=%0d type=%0d", ovc[0], otype[0], e.vc, e.ftype);
                end
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (oport[k] !== e.port[k]) begin
                        failures++;
                        $display("FAIL out_port dut=%0d port=%0d expected=%0d", k, oport[k], e.port[k]);
                    end
                end
            end
            prev_valid = ov[0];
            prev_hs    = hs;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_vc = '0; in_flit_type = HEAD;
        in_x_dest = '0; in_y_dest = '0; out_ready = 1'b1;
        model_reset();
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready in_ready=%b expected=1", rdy[0]);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ovc[k] !== 2'd0 || otype[k] !== 2'b00 || oport[k] !== LOCAL || err[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs dut=%0d valid=%b vc=%0d type=%0d port=%0d err=%b expected 0/0/0/0/0",
                         k, ov[k], ovc[k], otype[k], oport[k], err[k]);
            end
        end
        check_vca("reset_vc_active", 4'b0000);
        rst_n = 1'b1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_in_ready in_ready=%b expected=1", rdy[0]);
        end
    endtask

    task automatic test_xy_packet();
        send(0, HEAD, 0, 3);
        check_vca("head_vc_active", 4'b0001);
        send(0, BODY, 9, 9);
        send(0, TAIL, 9, 9);
        idle();
        check_vca("tail_vc_active", 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_yx_vs_xy();
        send(1, HEAD, 3, 0);
        check_vca("yx_head_vc_active", 4'b0010);
        send(1, TAIL, 0, 0);
        idle();
        @(negedge clk);
    endtask

    task automatic test_headtail();
        send(0, HEADTAIL, 5, 5);
        check_vca("headtail_vc_active", 4'b0000);
        send(1, HEADTAIL, 0, 5);
        send(2, HEADTAIL, 0, 2);
        idle();
        check_vca("headtail_vc_active_end", 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_interleave();
        send(0, HEAD, 3, 2);
        send(2, HEAD, 2, 0);
        check_vca("interleave_vc_active", 4'b0101);
        send(0, BODY, 0, 0);
        send(2, TAIL, 0, 0);
        send(0, TAIL, 0, 0);
        idle();
        check_vca("interleave_vc_active_end", 4'b0000);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send(0, HEAD, 4, 4);
        in_vc = 2'd0; in_flit_type = TAIL; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (rdy[0] !== 1'b0 || ov[0] !== 1'b1) begin
                failures++;
                $display("FAIL stall_ready cycle=%0d in_ready=%b out_valid=%b expected 0/1", c, rdy[0], ov[0]);
            end
            checks++;
            if (oport[0] !== EAST || otype[0] !== HEAD || ovc[0] !== 2'd0) begin
                failures++;
                $display("FAIL stall_hold cycle=%0d port=%0d type=%0d vc=%0d expected %0d/0/0", c, oport[0], otype[0], ovc[0], EAST);
            end
            check_vca("stall_vc_active", 4'b0001);
            @(negedge clk);
        end
        push_exp(0, TAIL, 0, 0);
        out_ready = 1'b1;
        @(negedge clk);
        idle();
        check_vca("release_vc_active", 4'b0000);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_protocol_errors();
        send(3, BODY, 0, 0);
        idle();
        checks++;
        if (err[0] !== 1'b1) begin
            failures++;
            $display("FAIL body_idle_err err=%b expected=1", err[0]);
        end
        @(negedge clk);
        checks++;
        if (err[0] !== 1'b0) begin
            failures++;
            $display("FAIL body_idle_err_width err=%b expected=0", err[0]);
        end
        send(0, HEAD, 1, 1);
        send(0, HEAD, 3, 3);
        idle();
        checks++;
        if (err[0] !== 1'b1) begin
            failures++;
            $display("FAIL head_active_err err=%b expected=1", err[0]);
        end
        check_vca("head_active_vc_active", 4'b0001);
        send(0, TAIL, 0, 0);
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_packet();
        send(2, HEAD, 0, 0);
        idle();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        sbq.delete();
        model_reset();
        #1;
        checks++;
        if (rdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_in_ready in_ready=%b expected=1", rdy[0]);
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (ov[k] !== 1'b0 || ovc[k] !== 2'd0 || otype[k] !== 2'b00 || oport[k] !== LOCAL || err[k] !== 1'b0) begin
                failures++;
                $display("FAIL mid_reset_outputs dut=%0d valid=%b vc=%0d type=%0d port=%0d err=%b expected 0/0/0/0/0",
                         k, ov[k], ovc[k], otype[k], oport[k], err[k]);
            end
        end
        check_vca("mid_reset_vc_active", 4'b0000);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(2, BODY, 0, 0);
        idle();
        checks++;
        if (err[0] !== 1'b1 || oport[0] !== LOCAL) begin
            failures++;
            $display("FAIL body_after_reset err=%b port=%0d expected 1/%0d", err[0], oport[0], LOCAL);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_xy_packet();
        test_yx_vs_xy();
        test_headtail();
        test_interleave();
        test_backpressure();
        test_protocol_errors();
        test_reset_mid_packet();
        repeat (3) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d expected=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
